// File: rtl/memory_arbiter.sv
// memory_arbiter: accepts instruction and data requests and serialises them
// onto one shared RAM port. Each granted request completes with a
// single-cycle iHit or dHit pulse. The load data is held in registers until
// the next matching hit.
//
// Ports:
//   CLK, nRST           clock (rising edge), asynchronous active-low reset
//   iRen, iaddr         instruction read request (level) and its address
//   dRen, dWen, daddr   data read / write request (level) and its address
//   dstore              data to write
//   iHit, dHit          one-cycle completion pulses
//   iload, dload        instruction word / load data, held between hits
//   ram_ren, ram_wen    RAM read / write strobes (held while BUSY)
//   ram_addr, ram_store RAM address and write data (latched at grant)
//   ram_load, ram_ready RAM read data and access-complete handshake
//   mem_err             sticky flag, set when a RAM access times out
module memory_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iRen,
   input  logic              dRen,
   input  logic              dWen,
   input  logic [ADDR_W-1:0] iaddr,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic              iHit,
   output logic              dHit,
   output logic [DATA_W-1:0] iload,
   output logic [DATA_W-1:0] dload,
   output logic              ram_ren,
   output logic              ram_wen,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_store,
   input  logic [DATA_W-1:0] ram_load,
   input  logic              ram_ready,
   output logic              mem_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OP_RD_I = 2'd0,
      OP_RD_D = 2'd1,
      OP_WR_D = 2'd2
   } op_t;

   // The counter only has to reach TIMEOUT-1. The timeout fires on the
   // TIMEOUT-th edge that samples ram_ready low.
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
   localparam bit TO_EN = (TIMEOUT != 0);

   state_t           state;
   op_t              op;
   logic             last_data;
   logic [CNT_W-1:0] cnt;

   logic data_req;
   logic any_req;
   logic grant_i;
   op_t  op_next;

   // Request arbitration. Data normally wins. The instruction side wins
   // right after a data transaction, so that data traffic cannot starve
   // fetch. If dRen and dWen are both high, the request is a write.
   always_comb begin
      data_req = dRen | dWen;
      any_req  = iRen | data_req;
      grant_i  = iRen & (~data_req | last_data);
      op_next  = OP_RD_D;
      if (grant_i) begin
         op_next = OP_RD_I;
      end else if (dWen) begin
         op_next = OP_WR_D;
      end else begin
         op_next = OP_RD_D;
      end
   end

   // Transaction FSM. The RAM strobes, hit pulses and load registers are all
   // driven from this block, so every output is registered.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= IDLE;
         op        <= OP_RD_I;
         last_data <= 1'b0;
         cnt       <= '0;
         iHit      <= 1'b0;
         dHit      <= 1'b0;
         iload     <= '0;
         dload     <= '0;
         ram_ren   <= 1'b0;
         ram_wen   <= 1'b0;
         ram_addr  <= '0;
         ram_store <= '0;
         mem_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               iHit <= 1'b0;
               dHit <= 1'b0;
               if (any_req) begin
                  op        <= op_next;
                  ram_addr  <= grant_i ? iaddr : daddr;
                  ram_store <= dstore;
                  ram_ren   <= (op_next != OP_WR_D);
                  ram_wen   <= (op_next == OP_WR_D);
                  cnt       <= '0;
                  state     <= BUSY;
               end else begin
                  ram_ren <= 1'b0;
                  ram_wen <= 1'b0;
               end
            end
            BUSY: begin
               if (ram_ready || (TO_EN && (cnt == CNT_LAST))) begin
                  // Completion path. On a timeout the read returns zero and
                  // the error flag latches.
                  ram_ren <= 1'b0;
                  ram_wen <= 1'b0;
                  state   <= RESP;
                  if (!ram_ready) begin
                     mem_err <= 1'b1;
                  end else begin
                     mem_err <= mem_err;
                  end
                  case (op)
                     OP_RD_I: begin
                        iload <= ram_ready ? ram_load : '0;
                        iHit  <= 1'b1;
                     end
                     OP_RD_D: begin
                        dload <= ram_ready ? ram_load : '0;
                        dHit  <= 1'b1;
                     end
                     default: begin
                        dHit <= 1'b1;
                     end
                  endcase
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RESP: begin
               iHit      <= 1'b0;
               dHit      <= 1'b0;
               last_data <= (op != OP_RD_I);
               state     <= IDLE;
            end
            default: begin
               iHit    <= 1'b0;
               dHit    <= 1'b0;
               ram_ren <= 1'b0;
               ram_wen <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Responder side of the processor's fetch/data request interface.
- Accepts instruction-read, data-read and data-write requests from the request/fetch logic.
- Serialises them onto a single shared RAM port and returns one-cycle iHit/dHit pulses together with the load data.
- Sits between the datapath's request unit and the RAM model or cache-less memory.

Parameters:
- ADDR_W, 32, address width of iaddr/daddr/ram_addr
- DATA_W, 32, width of store/load data
- TIMEOUT, 16, maximum BUSY cycles waiting for ram_ready before a forced error response; 0 disables the timeout

Ports:
- CLK  input  1  system clock, rising edge
- nRST  input  1  asynchronous active-low reset
- iRen  input  1  instruction read request (level)
- dRen  input  1  data read request (level)
- dWen  input  1  data write request (level)
- iaddr  input  ADDR_W  instruction address
- daddr  input  ADDR_W  data address
- dstore  input  DATA_W  data to write
- iHit  output  1  one-cycle pulse: instruction request complete
- dHit  output  1  one-cycle pulse: data request complete
- iload  output  DATA_W  instruction word, held until the next iHit
- dload  output  DATA_W  load data, held until the next read dHit
- ram_ren  output  1  RAM read strobe
- ram_wen  output  1  RAM write strobe
- ram_addr  output  ADDR_W  RAM address
- ram_store  output  DATA_W  RAM write data
- ram_load  input  DATA_W  RAM read data, valid when ram_ready=1
- ram_ready  input  1  RAM has completed the current access
- mem_err  output  1  sticky timeout flag

Behaviour:
- Reset (async, nRST=0): state IDLE, last_data=0, timeout counter=0.
  - All outputs 0: iHit, dHit, iload, dload, ram_ren, ram_wen, ram_addr, ram_store, mem_err.
  - Reset mid-transaction aborts it immediately; RAM strobes drop without waiting for a clock edge.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Evaluates requests each cycle.
  - Data request = dRen|dWen.
  - Data wins over instruction, except when last_data=1 and iRen=1: then instruction wins (alternation prevents fetch starvation).
  - On grant: latch op (RD_I, RD_D, WR_D), address and dstore into internal registers; next state BUSY; clear the timeout counter.
  - No request: stay in IDLE, strobes 0.
- dRen and dWen both high: treated as write; no error is raised.
- BUSY:
  - Drive ram_ren=1 for reads, ram_wen=1 for writes; ram_addr and ram_store come from the latched registers, never from live inputs.
  - Inputs changing or being withdrawn during BUSY has no effect; the transaction completes and the hit is still pulsed (requester ignores it).
  - ram_ready=1 sampled on an edge: capture ram_load into iload (RD_I) or dload (RD_D); on writes, the load registers are unchanged. Next state RESP.
  - ram_ready=0: the counter increments.
  - When TIMEOUT!=0 and the counter reaches TIMEOUT: go to RESP, the read load register is written with 0, and mem_err is set. mem_err stays set until reset.
- RESP:
  - Strobes 0; exactly one of iHit/dHit is 1 for this single cycle.
  - last_data is updated: 1 if the completed op was data, else 0.
  - Next state is always IDLE, so a new grant occurs at the earliest one cycle after the hit.
- Latency:
  - Request granted in IDLE at edge N; BUSY for cycles N+1..M, where M is the first edge sampling ram_ready=1; hit visible in cycle M+1.
  - Minimum request-to-hit is 2 cycles (ram_ready already high in the first BUSY cycle).
  - Back-to-back transactions: 3 cycles each minimum.
- iHit and dHit are never high simultaneously; ram_ren and ram_wen are never high simultaneously.
- Load outputs are registered and stable while hit=0.

Test Plan:
- Reset, then release with no requests -> all outputs 0, state IDLE for 10 cycles, ram_ren=ram_wen=0.
- iRen=1, iaddr=0x00000004, RAM returns 0x8C010000 with ram_ready high on first BUSY cycle -> ram_ren=1 with ram_addr=0x4 for one cycle, iHit pulse 2 cycles after grant, iload=0x8C010000 held afterward.
- iRen=1 and dWen=1 together, daddr=0x100, dstore=0xDEADBEEF, last_data=0 -> data write served first (ram_wen=1, ram_store=0xDEADBEEF), dHit pulse; instruction fetch then granted next even though dWen still high (alternation), iHit follows.
- dRen=1, daddr=0x200, ram_ready delayed 5 cycles, daddr changed to 0x300 mid-BUSY -> ram_addr stays 0x200 for all 5 cycles, dload=RAM value, dHit once, mem_err=0.
- TIMEOUT=16, dRen=1, ram_ready held 0 -> after 16 BUSY cycles dHit pulses with dload=0, mem_err=1 and remains 1 through later successful accesses until nRST.
- nRST asserted during BUSY with ram_ren=1 -> ram_ren drops immediately (before next edge), no hit pulse, and after release the pending request restarts from IDLE.
